keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 194 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-based debounce.
//
// Drives one keypad row low at a time, samples the synchronized columns at the
// end of each row slot, and after four slots evaluates the whole frame.
// Accepted keys are reported as a 4-bit hex code {row, col}.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   col[3:0]   in   keypad columns, active-low, asynchronous to clk
//   row[3:0]   out  keypad row drive, active-low one-hot
//   key[3:0]   out  hex code of the last accepted key (kept after release)
//   key_valid  out  one-cycle pulse when a new key is accepted
//   key_held   out  high while the accepted key is considered pressed
//   multi_key  out  high when the last completed frame saw more than one key
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [DIV_W-1:0] SLOT_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_M1    = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // Column synchronizer
  logic [3:0] r_col_meta;
  logic [3:0] r_col_sync;

  // Row scanning
  logic [DIV_W-1:0] r_slot_cnt;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_row;

  // Frame capture: bit (r*4 + c) set means key at row r, column c was seen
  // pressed, so a single set bit's index is directly the key code.
  logic [15:0] r_samp;
  logic        r_eval;

  // Debounce state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand;
  logic [3:0]       r_key;
  logic             r_key_valid;
  logic             r_key_held;
  logic             r_multi_key;

  // Frame classification
  logic       w_empty;
  logic       w_single;
  logic       w_multi;
  logic [3:0] w_code;

  assign row       = r_row;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign multi_key = r_multi_key;

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_meta <= 4'b1111;
      r_col_sync <= 4'b1111;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
    end
  end

  // Row slot timer, row rotation, end-of-slot sampling and frame-done strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_row_idx  <= 2'd0;
      r_row      <= 4'b1110;
      r_samp     <= 16'h0000;
      r_eval     <= 1'b0;
    end else begin
      r_eval <= 1'b0;
      if (r_slot_cnt == SLOT_LAST) begin
        r_slot_cnt                     <= '0;
        r_row_idx                      <= r_row_idx + 2'd1;
        r_row                          <= {r_row[2:0], r_row[3]};
        r_samp[{r_row_idx, 2'b00} +: 4] <= ~r_col_sync;
        // Row3 sample lands on this edge, so the frame is whole next cycle
        if (r_row_idx == 2'd3) begin
          r_eval <= 1'b1;
        end
      end else begin
        r_slot_cnt <= r_slot_cnt + DIV_W'(1);
      end
    end
  end

  // Frame classification: empty, exactly one key (power of two), or several
  always_comb begin
    w_empty  = (r_samp == 16'h0000);
    w_single = !w_empty && ((r_samp & (r_samp - 16'h0001)) == 16'h0000);
    w_multi  = !w_empty && !w_single;
    w_code   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (r_samp[i]) begin
        w_code = 4'(i);
      end
    end
  end

  // Debounce / press-tracking FSM, advanced once per evaluated frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= 4'h0;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_eval) begin
        r_multi_key <= w_multi;
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_state <= S_DEBOUNCE;
              r_cand  <= w_code;
              r_cnt   <= CNT_W'(1);
            end
          end
          S_DEBOUNCE: begin
            if (w_single && (w_code == r_cand)) begin
              if (r_cnt == DEB_M1) begin
                r_state     <= S_PRESSED;
                r_key       <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_cnt       <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end
          S_PRESSED: begin
            // Extra or different keys are ignored while a key is held
            if (w_empty) begin
              r_state <= S_RELEASE;
              r_cnt   <= CNT_W'(1);
            end
          end
          S_RELEASE: begin
            if (w_empty) begin
              if (r_cnt == DEB_M1) begin
                r_state    <= S_IDLE;
                r_key_held <= 1'b0;
                r_cnt      <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_state <= S_PRESSED;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan: a keypad matrix model drives col from row, and a
// frame-level model predicts key/key_valid/key_held/multi_key and row timing.
module tb_keypad_scan;

  localparam int unsigned SD  = 4;
  localparam int unsigned DEB = 3;
  localparam int unsigned F   = 4 * SD;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  // Pressed keys: bit r*4+c = key at row r, column c
  logic [15:0] keys;

  // Physical keypad: a pressed key pulls its column low while its row is driven
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~keys[4*r +: 4];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int unsigned cyc;
  bit chk_en;
  int valid_seen;
  int last_valid_cyc;

  // Expected outputs now, and those the next frame evaluation will produce
  logic [3:0] exp_key, pend_key;
  logic       exp_valid, pend_valid;
  logic       exp_held, pend_held;
  logic       exp_multi, pend_multi;

  // Frame-level model
  bit         m_held;
  int         m_streak;
  logic [3:0] m_cand;
  logic [3:0] m_key;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  logic [3:0] exp_row;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_row = 4'b1111 ^ (4'b0001 << 2'((cyc / SD) % 4));
      check("row", 32'(row), 32'(exp_row));
      check("key", 32'(key), 32'(exp_key));
      check("key_valid", 32'(key_valid), 32'(exp_valid));
      check("key_held", 32'(key_held), 32'(exp_held));
      check("multi_key", 32'(multi_key), 32'(exp_multi));
      if (key_valid === 1'b1) begin
        valid_seen++;
        last_valid_cyc = int'(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    m_held = 0; m_streak = 0; m_cand = 4'h0; m_key = 4'h0;
    exp_key = 4'h0; exp_valid = 1'b0; exp_held = 1'b0; exp_multi = 1'b0;
    pend_key = 4'h0; pend_valid = 1'b0; pend_held = 1'b0; pend_multi = 1'b0;
  endtask

  // Apply the debounce rules to one whole frame of pressed keys
  task automatic model_frame(input logic [15:0] pat);
    int n;
    logic [3:0] code;
    n = $countones(pat);
    code = 4'h0;
    for (int i = 0; i < 16; i++) if (pat[i]) code = 4'(i);
    pend_multi = (n >= 2);
    pend_valid = 1'b0;
    if (!m_held) begin
      if (m_streak == 0) begin
        if (n == 1) begin m_cand = code; m_streak = 1; end
      end else if (n == 1 && code == m_cand) begin
        m_streak++;
        if (m_streak == DEB) begin
          m_held = 1; m_key = m_cand; m_streak = 0; pend_valid = 1'b1;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (n == 0) begin
        m_streak++;
        if (m_streak == DEB) begin m_held = 0; m_streak = 0; end
      end else begin
        m_streak = 0;
      end
    end
    pend_key  = m_key;
    pend_held = m_held;
  endtask

  // Start of frame (cycle 0) up to cycle 2; previous frame's results show at cycle 1
  task automatic half1(input logic [15:0] pat);
    keys = pat;
    tick();
    exp_key = pend_key; exp_valid = pend_valid; exp_held = pend_held; exp_multi = pend_multi;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic half2(input logic [15:0] pat);
    repeat (F - 2) tick();
    model_frame(pat);
  endtask

  task automatic do_frame(input logic [15:0] pat);
    half1(pat);
    half2(pat);
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst = 1'b1;
    keys = 16'h0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    model_clear();
    chk_en = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row"}, 32'(row), 32'h0000_000E);
    check({tag, "_key"}, 32'(key), 32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_held"}, 32'(key_held), 32'h0);
    check({tag, "_multi"}, 32'(multi_key), 32'h0);
  endtask

  int v0;
  int kind;
  int reps;
  logic [15:0] pat;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; chk_en = 0;
    valid_seen = 0; last_valid_cyc = -1;
    keys = 16'h0000;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk_en = 1;
    check_reset_vals("init");

    // Steady press row1/col2 -> code 6, pulse one cycle after third evaluation
    do_reset();
    v0 = valid_seen;
    repeat (3) do_frame(16'h0040);
    half1(16'h0040);
    check("press_pulses", 32'(valid_seen - v0), 32'd1);
    check("press_latency", 32'(last_valid_cyc), 32'd49);
    check("press_key", 32'(key), 32'h6);
    check("press_held", 32'(key_held), 32'h1);
    half2(16'h0040);

    // Bouncing key in alternate frames is never accepted
    do_reset();
    v0 = valid_seen;
    for (int i = 0; i < 8; i++) do_frame((i % 2 == 0) ? 16'h0040 : 16'h0000);
    half1(16'h0000);
    check("bounce_pulses", 32'(valid_seen - v0), 32'd0);
    check("bounce_held", 32'(key_held), 32'h0);
    half2(16'h0000);

    // Two keys together from idle flag multi_key, no acceptance
    do_reset();
    v0 = valid_seen;
    do_frame(16'h0801);
    half1(16'h0000);
    check("multi_set", 32'(multi_key), 32'h1);
    check("multi_pulses", 32'(valid_seen - v0), 32'd0);
    half2(16'h0000);
    half1(16'h0000);
    check("multi_clear", 32'(multi_key), 32'h0);
    half2(16'h0000);

    // Hold 5, add 9, drop 5: no rollover; then full release keeps key
    do_reset();
    v0 = valid_seen;
    repeat (3) do_frame(16'h0020);
    repeat (2) do_frame(16'h0220);
    repeat (2) do_frame(16'h0200);
    check("roll_pulses", 32'(valid_seen - v0), 32'd1);
    check("roll_key", 32'(key), 32'h5);
    check("roll_held", 32'(key_held), 32'h1);
    repeat (3) do_frame(16'h0000);
    half1(16'h0000);
    check("release_held", 32'(key_held), 32'h0);
    check("release_key", 32'(key), 32'h5);
    check("release_pulses", 32'(valid_seen - v0), 32'd1);
    half2(16'h0000);

    // Single empty frame while pressed does not release
    do_reset();
    v0 = valid_seen;
    repeat (3) do_frame(16'h0040);
    do_frame(16'h0000);
    repeat (2) do_frame(16'h0040);
    half1(16'h0040);
    check("glitch_held", 32'(key_held), 32'h1);
    check("glitch_pulses", 32'(valid_seen - v0), 32'd1);
    half2(16'h0040);

    // Reset during debounce discards progress
    do_reset();
    repeat (2) do_frame(16'h0040);
    half1(16'h0040);
    do_reset();
    check_reset_vals("midrst");
    v0 = valid_seen;
    repeat (2) do_frame(16'h0040);
    half1(16'h0040);
    check("midrst_early", 32'(valid_seen - v0), 32'd0);
    half2(16'h0040);
    half1(16'h0040);
    check("midrst_pulses", 32'(valid_seen - v0), 32'd1);
    check("midrst_latency", 32'(last_valid_cyc), 32'd49);
    half2(16'h0040);

    // Randomized runs of repeated frames, with occasional mid-frame reset
    do_reset();
    for (int run = 0; run < 60; run++) begin
      kind = int'($urandom_range(0, 9));
      reps = int'($urandom_range(1, 5));
      if (kind < 2) begin
        pat = 16'h0000;
      end else if (kind < 8) begin
        pat = 16'h0001 << $urandom_range(0, 15);
      end else begin
        pat = 16'($urandom);
        if ($countones(pat) < 2) pat = 16'h8001;
      end
      if ($urandom_range(0, 19) == 0) begin
        half1(pat);
        do_reset();
      end else begin
        repeat (reps) do_frame(pat);
      end
    end
    repeat (2) do_frame(16'h0000);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
